// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, fill-level flags and sticky
// overflow/underflow error bits. Storage is never cleared; pointers define validity.
module param_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int FIFO_SIZE = 16,
  parameter int PTR_WIDTH = $clog2(FIFO_SIZE),
  parameter int AF_LEVEL  = FIFO_SIZE - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     rdata,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH:0]   DEPTH = (PTR_WIDTH+1)'(FIFO_SIZE);
  localparam logic [PTR_WIDTH:0]   AF_T  = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]   AE_T  = (PTR_WIDTH+1)'(AE_LEVEL);
  localparam logic [PTR_WIDTH-1:0] LAST  = PTR_WIDTH'(FIFO_SIZE - 1);

  logic [WIDTH-1:0]     mem [FIFO_SIZE];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                 rd_acc, wr_acc, ovf_set, unf_set;

  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // paired with a read; an empty FIFO never bypasses write data to rdata.
  assign rd_acc  = rd_en & ~empty;
  assign wr_acc  = wr_en & (~full | rd_acc);
  assign ovf_set = wr_en & full & ~rd_acc;
  assign unf_set = rd_en & empty;

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) begin
        rd_ptr <= ptr_next(rd_ptr);
        rdata  <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush ignores the request lines, so it neither raises nor clears errors.
  always_ff @(posedge clk) begin
    if (res) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!res && !flush && wr_acc) mem[wr_ptr] <= wdata;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: hand-computed vector table, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_param_sync_fifo;
  localparam int W = 8, N = 16, PW = $clog2(N), AF = 14, AE = 2;

  logic          clk = 1'b0;
  logic          res = 1'b0, wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic [PW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  always #5 clk = ~clk;

  param_sync_fifo #(.WIDTH(W), .FIFO_SIZE(N), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .rdata(rdata), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow));

  int n_cmp = 0, n_bad = 0;

  // reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_rdata = '0;
  bit           m_ovf = 0, m_unf = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit e0, f0, rd_ok, wr_ok, so, su;
    if (res) begin
      q.delete(); m_rdata = '0; m_ovf = 0; m_unf = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      e0 = (q.size() == 0);
      f0 = (q.size() == N);
      rd_ok = rd_en && !e0;
      wr_ok = wr_en && (!f0 || rd_ok);
      so = wr_en && f0 && !rd_ok;
      su = rd_en && e0;
      if (rd_ok) m_rdata = q.pop_front();
      if (wr_ok) q.push_back(wdata);
      m_ovf = so || (m_ovf && !clr_err);
      m_unf = su || (m_unf && !clr_err);
    end
  endtask

  task automatic chk_model();
    int sz = q.size();
    chk("m_rdata", rdata, m_rdata);
    chk("m_count", count, sz);
    chk("m_full", full, sz == N);
    chk("m_empty", empty, sz == 0);
    chk("m_afull", almost_full, sz >= AF);
    chk("m_aempty", almost_empty, sz <= AE);
    chk("m_ovf", overflow, m_ovf);
    chk("m_unf", underflow, m_unf);
  endtask

  // apply one cycle of inputs, advance the model, compare just after the edge
  task automatic cyc(input bit r, input bit w, input bit rd, input bit fl, input bit cl,
                     input logic [W-1:0] d);
    res = r; wr_en = w; rd_en = rd; flush = fl; clr_err = cl; wdata = d;
    @(posedge clk);
    #1;
    model_step();
    chk_model();
  endtask

  typedef struct {
    bit r, w, rd, fl, cl;
    logic [W-1:0] d;
    int cnt;
    logic [W-1:0] rdat;
    bit ovf, unf;
  } vec_t;

  vec_t tbl[12];
  logic [W-1:0] last;

  initial begin
    tbl[0]  = '{1,0,0,0,0,8'h00, 0, 8'h00, 0, 0};
    tbl[1]  = '{0,0,1,0,0,8'h00, 0, 8'h00, 0, 1};
    tbl[2]  = '{0,1,0,0,0,8'hA1, 1, 8'h00, 0, 1};
    tbl[3]  = '{0,1,0,0,0,8'hB2, 2, 8'h00, 0, 1};
    tbl[4]  = '{0,1,1,0,0,8'hC3, 2, 8'hA1, 0, 1};
    tbl[5]  = '{0,0,0,0,1,8'h00, 2, 8'hA1, 0, 0};
    tbl[6]  = '{0,0,1,0,0,8'h00, 1, 8'hB2, 0, 0};
    tbl[7]  = '{0,1,0,1,0,8'hD4, 0, 8'hB2, 0, 0};
    tbl[8]  = '{0,0,1,0,0,8'h00, 0, 8'hB2, 0, 1};
    tbl[9]  = '{0,1,0,0,0,8'h5E, 1, 8'hB2, 0, 1};
    tbl[10] = '{0,0,1,0,1,8'h00, 0, 8'h5E, 0, 0};
    tbl[11] = '{1,1,1,0,0,8'h77, 0, 8'h00, 0, 0};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].fl, tbl[i].cl, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdat);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), underflow, tbl[i].unf);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].cnt == 0);
      chk($sformatf("tbl%0d_aempty", i), almost_empty, tbl[i].cnt <= AE);
    end

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 0, 0, 0, W'(i));
      chk("fill_count", count, i);
      chk("fill_afull", almost_full, i >= 14);
      chk("fill_full", full, i == 16);
    end
    // write alone at full is dropped
    cyc(0, 1, 0, 0, 0, 8'hAA);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    cyc(0, 0, 0, 0, 1, 8'h00);
    chk("ovf_clr", overflow, 0);
    // write+read at full keeps the level
    cyc(0, 1, 1, 0, 0, 8'h55);
    chk("fullrw_count", count, 16);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_rdata", rdata, 8'h01);
    for (int i = 2; i <= 17; i++) begin
      cyc(0, 0, 1, 0, 0, 8'h00);
      chk("drain_rdata", rdata, (i == 17) ? 8'h55 : W'(i));
    end
    chk("drain_empty", empty, 1);
    // read+write at empty: read rejected, write taken
    cyc(0, 1, 1, 0, 0, 8'h33);
    chk("emptyrw_unf", underflow, 1);
    chk("emptyrw_rdata", rdata, 8'h55);
    chk("emptyrw_count", count, 1);
    cyc(0, 0, 1, 0, 1, 8'h00);
    chk("emptyrw_next", rdata, 8'h33);
    chk("emptyrw_clr", underflow, 0);

    // interleaved push/pop of 20 crossing the pointer wrap
    for (int k = 0; k < 20; k++) cyc(0, 1, k % 2 == 1, 0, 0, W'(8'h80 + k));
    chk("wrap_mid_count", count, 10);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, 0, 0, 8'h00);
      chk("wrap_aempty", almost_empty, (9 - k) <= 2);
    end
    chk("wrap_last", rdata, 8'h93);

    // flush with write pending, then reset in mid-burst
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, W'(8'h11 + i));
    cyc(0, 1, 0, 1, 0, 8'h99);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_rdata", rdata, 8'h93);
    cyc(0, 1, 0, 0, 0, 8'h21);
    cyc(0, 1, 1, 0, 0, 8'h22);
    cyc(1, 1, 1, 0, 0, 8'h23);
    chk("rst_count", count, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    cyc(0, 1, 0, 0, 0, 8'h44);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("rst_fresh", rdata, 8'h44);

    // random traffic, write bias rotating to visit full and empty
    for (int i = 0; i < 3000; i++) begin
      int wp;
      case ((i / 150) % 3)
        0:       wp = 80;
        1:       wp = 20;
        default: wp = 50;
      endcase
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < wp),
          ($urandom_range(0, 99) < 100 - wp + 10), ($urandom_range(0, 119) == 0),
          ($urandom_range(0, 9) == 0), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
